// File: rtl/bus_arbiter.sv
// Two-master (instruction/data), one-slave bus arbiter with a registered
// round-robin owner that can hand the bus over after any acknowledged beat.
module bus_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] i_adr_i,
  input  logic [1:0]  i_size_i,
  output logic [15:0] i_dat_o,
  output logic        i_ack_o,
  input  logic [63:0] d_adr_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_we_i,
  input  logic [15:0] d_dat_i,
  output logic [15:0] d_dat_o,
  output logic        d_ack_o,
  output logic [63:0] adr_o,
  output logic [1:0]  size_o,
  output logic        we_o,
  output logic [15:0] dat_o,
  input  logic [15:0] dat_i,
  input  logic        ack_i,
  output logic [1:0]  gnt_o
);

  // Encoding doubles as the gnt_o value, so the grant output is the raw state.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_IGNT = 2'b01,
    OWN_DGNT = 2'b10
  } own_t;

  own_t r_own;
  logic r_last;   // 0 = instruction granted last, 1 = data granted last
  logic w_ireq;
  logic w_dreq;

  assign w_ireq = (i_size_i != 2'd0);
  assign w_dreq = (d_size_i != 2'd0);

  // Owner FSM: the owner keeps the bus through wait states and only yields on
  // an acked beat (if the other master is waiting) or when it withdraws.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_own  <= OWN_IDLE;
      r_last <= 1'b1;
    end else begin
      case (r_own)
        OWN_IDLE: begin
          if (w_ireq && (!w_dreq || r_last)) begin
            r_own  <= OWN_IGNT;
            r_last <= 1'b0;
          end else if (w_dreq) begin
            r_own  <= OWN_DGNT;
            r_last <= 1'b1;
          end
        end
        OWN_IGNT: begin
          if (!w_ireq) begin
            if (w_dreq) begin
              r_own  <= OWN_DGNT;
              r_last <= 1'b1;
            end else begin
              r_own <= OWN_IDLE;
            end
          end else if (ack_i && w_dreq) begin
            r_own  <= OWN_DGNT;
            r_last <= 1'b1;
          end
        end
        OWN_DGNT: begin
          if (!w_dreq) begin
            if (w_ireq) begin
              r_own  <= OWN_IGNT;
              r_last <= 1'b0;
            end else begin
              r_own <= OWN_IDLE;
            end
          end else if (ack_i && w_ireq) begin
            r_own  <= OWN_IGNT;
            r_last <= 1'b0;
          end
        end
        default: r_own <= OWN_IDLE;
      endcase
    end
  end

  // Bus outputs follow the owner combinationally; an async reset of r_own
  // therefore idles the bus without waiting for a clock edge.
  always_comb begin
    adr_o  = '0;
    size_o = '0;
    we_o   = 1'b0;
    dat_o  = '0;
    case (r_own)
      OWN_IGNT: begin
        adr_o  = i_adr_i;
        size_o = i_size_i;
      end
      OWN_DGNT: begin
        adr_o  = d_adr_i;
        size_o = d_size_i;
        we_o   = d_we_i;
        dat_o  = d_dat_i;
      end
      default: ;
    endcase
  end

  assign gnt_o   = r_own;
  assign i_dat_o = dat_i;
  assign d_dat_o = dat_i;
  assign i_ack_o = ack_i && (r_own == OWN_IGNT) && w_ireq;
  assign d_ack_o = ack_i && (r_own == OWN_DGNT) && w_dreq;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter sitting directly upstream of the instruction fetch stage. It shares the single 16-bit external bus between the fetch stage (instruction master) and the load/store unit (data master), using a registered round-robin grant that can hand the bus over after any acknowledged beat. The bus protocol is the same on every port: a nonzero size requests a cycle, the master holds its request until ack, and data is valid on the acked edge.

## Interface
Parameters:
- none (bus widths fixed: 64-bit address, 16-bit data, 2-bit size)

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- reset_i  in  1  reset, asynchronous, active-low
- i_adr_i  in  64  instruction master address
- i_size_i  in  2  instruction master size; 0 = no request
- i_dat_o  out  16  read data to instruction master
- i_ack_o  out  1  beat acknowledge to instruction master
- d_adr_i  in  64  data master address
- d_size_i  in  2  data master size; 0 = no request
- d_we_i  in  1  data master write enable
- d_dat_i  in  16  data master write data
- d_dat_o  out  16  read data to data master
- d_ack_o  out  1  beat acknowledge to data master
- adr_o  out  64  bus address
- size_o  out  2  bus size; 0 = bus idle
- we_o  out  1  bus write enable
- dat_o  out  16  bus write data
- dat_i  in  16  bus read data
- ack_i  in  1  bus acknowledge
- gnt_o  out  2  current grant: 00 idle, 01 instruction, 10 data

## Operation
- State register `own`, one of IDLE, IGNT, DGNT. Flag `last` records the most recently granted master.
- Reset (reset_i low) forces `own`=IDLE and `last`=data, so the instruction master wins the first tie.
- Reset value of every output: adr_o=0, size_o=0, we_o=0, dat_o=0, i_ack_o=0, d_ack_o=0, gnt_o=00, i_dat_o=dat_i, d_dat_o=dat_i.
- Outputs are combinational from `own`:
  - IDLE: adr_o=0, size_o=0, we_o=0, dat_o=0.
  - IGNT: adr_o=i_adr_i, size_o=i_size_i, we_o=0, dat_o=0.
  - DGNT: adr_o=d_adr_i, size_o=d_size_i, we_o=d_we_i, dat_o=d_dat_i.
- i_dat_o and d_dat_o always pass dat_i through unchanged.
- Acknowledge gating:
  - i_ack_o = ack_i & (own==IGNT) & (i_size_i!=0)
  - d_ack_o = ack_i & (own==DGNT) & (d_size_i!=0)
  - ack_i while the bus is idle is ignored.
- Transitions at each rising edge. Let ireq = i_size_i!=0 and dreq = d_size_i!=0.
  - IDLE: if ireq and dreq, grant the master that is not `last`; if only one requests, grant it; if neither, stay IDLE.
  - IGNT:
    - if !ireq, go to DGNT if dreq, else IDLE.
    - else if ack_i and dreq, go to DGNT.
    - else stay IGNT.
  - DGNT: mirror image of IGNT.
  - `last` updates to the new owner on every entry into IGNT or DGNT.
- A request is never split. The owner keeps the bus through wait states (ack_i low) regardless of the other master. Hand-over happens only on an acked beat or when the owner withdraws.
- A 32-bit fetch made of two 16-bit beats may interleave with a data beat between them. The fetch stage tolerates this because it holds its address until acked.
- The owner dropping size to 0 without ack is an abort: size_o goes to 0 in the same cycle and no ack is delivered.

## Timing
- Request to bus from IDLE: 1 cycle. The request is sampled at edge N; adr_o and size_o are valid after edge N.
- Back-to-back beats by the same owner with no competitor: 0 dead cycles.
- Hand-over: on the acked edge `own` switches, so the new master's address is on the bus in the very next cycle (0 dead cycles).
- Acks are combinational from ack_i with no registering. Read data is valid on the same edge as the ack.
- Async reset mid-beat: size_o drops to 0 immediately, without waiting for a clock edge. Any in-flight ack is discarded. After reset_i is released, arbitration restarts from IDLE.

## Test plan
- **Reset:** hold reset_i=0 with i_size_i=2 and d_size_i=2 → size_o=0, gnt_o=00, both acks 0. Release reset → gnt_o=01 and adr_o=i_adr_i after the first edge.
- **Instruction alone:** i_adr_i=FFFFFFFFFFFFFF00, i_size_i=2, ack_i=1, dat_i=AAAA → i_ack_o=1, i_dat_o=AAAA, adr_o follows i_adr_i (…FF02 next), d_ack_o stays 0.
- **Round-robin:** both masters request continuously, d_we_i=1, d_dat_i=1234, ack_i=1 → gnt_o alternates 01,10,01,10 on each edge. we_o=1 and dat_o=1234 only while gnt_o=10.
- **Wait states:** in IGNT with ack_i=0 for 4 cycles and dreq=1 → gnt_o stays 01 and adr_o is stable. ack_i=1 → one i_ack_o pulse, then gnt_o=10.
- **Abort and idle:** in DGNT, d_size_i→0 with no ack and ireq=0 → size_o=0 in the same cycle, gnt_o=00 after the edge. A spurious ack_i=1 while idle → both acks 0.
- **Async reset mid-beat:** assert reset_i low between edges during a DGNT beat → size_o=0 and d_ack_o=0 immediately. After release with both masters requesting → instruction wins the first grant.
